// File: rtl/apb_bridge_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS transfer out,
// registered response with slave error capture and bounded-wait timeout.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1, waiting on pready (or timeout)
// RESP   | rsp_valid high until rsp_ready handshake
module apb_bridge_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic              cmd_ready_nxt, busy_nxt;

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    psel_nxt        = psel;
    penable_nxt     = penable;
    pwrite_nxt      = pwrite;
    paddr_nxt       = paddr;
    pwdata_nxt      = pwdata;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt    = ST_SETUP;
          psel_nxt     = 1'b1;
          penable_nxt  = 1'b0;
          pwrite_nxt   = cmd_write;
          paddr_nxt    = cmd_addr;
          pwdata_nxt   = cmd_write ? cmd_wdata : '0;
          wait_cnt_nxt = '0;
        end
      end
      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_nxt       = ST_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = pwrite ? '0 : prdata;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
        end else begin
          // saturate rather than wrap so a disabled timeout never aliases
          if (wait_cnt != '1) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt_nxt == TO_VAL)) begin
            state_nxt       = ST_RESP;
            psel_nxt        = 1'b0;
            penable_nxt     = 1'b0;
            rsp_valid_nxt   = 1'b1;
            rsp_rdata_nxt   = '0;
            rsp_err_nxt     = 1'b1;
            rsp_timeout_nxt = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt     = ST_IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt      = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      cmd_ready   <= cmd_ready_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_apb_bridge_master.sv
// Scoreboard bench for apb_bridge_master: random and directed commands against a
// transaction-level model; second instance covers the disabled-timeout case.
module tb_apb_bridge_master;
  localparam int TO = 16;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite, busy;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata = '0;
  logic       pready = 1'b0, pslverr = 1'b0;

  logic       n_cmd_valid = 1'b0, n_cmd_ready;
  logic [7:0] n_cmd_addr = '0;
  logic       n_rsp_valid, n_rsp_err, n_rsp_timeout;
  logic [7:0] n_rsp_rdata;
  logic       n_psel, n_penable, n_pwrite, n_busy;
  logic [7:0] n_paddr, n_pwdata;
  logic [7:0] n_prdata = '0;
  logic       n_pready = 1'b0;

  apb_bridge_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .busy(busy));

  apb_bridge_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(0)) dut_nt (
    .pclk(pclk), .preset(preset), .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready),
    .cmd_write(1'b0), .cmd_addr(n_cmd_addr), .cmd_wdata(8'h00),
    .rsp_valid(n_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(n_rsp_rdata),
    .rsp_err(n_rsp_err), .rsp_timeout(n_rsp_timeout), .psel(n_psel), .penable(n_penable),
    .pwrite(n_pwrite), .paddr(n_paddr), .pwdata(n_pwdata), .prdata(n_prdata),
    .pready(n_pready), .pslverr(1'b0), .busy(n_busy));

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc++;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: bound expired, got no event expected event (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr, wdata, rdata;
    bit         err, to;
    int         access, exp_cyc;
  } exp_t;
  exp_t sb[$];

  // APB slave model: the configured transfer answers after slv_waits low-pready cycles
  int         slv_waits = 0, slv_cnt = 0;
  logic [7:0] slv_data = '0;
  bit         slv_err = 0;
  always @(posedge pclk) begin
    #1;
    if (psel && penable) begin
      if (slv_cnt == slv_waits) begin
        pready = 1'b1; prdata = slv_data; pslverr = slv_err;
      end else begin
        pready = 1'b0; prdata = 8'($urandom); pslverr = 1'($urandom);
      end
      slv_cnt++;
    end else begin
      slv_cnt = 0; pready = 1'($urandom); prdata = 8'($urandom); pslverr = 1'($urandom);
    end
  end

  bit rand_rdy = 0;
  int hold_left = 0;
  always @(posedge pclk) begin
    #1;
    if (hold_left > 0) begin
      rsp_ready = 1'b0;
      if (rsp_valid) hold_left--;
    end else begin
      rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  int  access_cnt = 0;
  bit  setup_seen = 0, prev_rv = 0;
  always @(negedge pclk) begin
    if (preset) begin
      sb.delete(); access_cnt = 0; setup_seen = 0; prev_rv = 0;
    end else begin
      if (psel) begin
        if (sb.size() == 0) check("psel_without_cmd", 32'(psel), 32'd0);
        else begin
          check("paddr", 32'(paddr), 32'(sb[0].addr));
          check("pwrite", 32'(pwrite), 32'(sb[0].wr));
          check("pwdata", 32'(pwdata), sb[0].wr ? 32'(sb[0].wdata) : 32'd0);
          if (!setup_seen) begin
            check("setup_penable", 32'(penable), 32'd0);
            setup_seen = 1;
          end else begin
            check("access_penable", 32'(penable), 32'd1);
            access_cnt++;
          end
        end
      end
      if (rsp_valid) begin
        if (sb.size() == 0) check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        else begin
          if (!prev_rv) check("rsp_latency", 32'(cyc), 32'(sb[0].exp_cyc));
          check("rsp_rdata", 32'(rsp_rdata), 32'(sb[0].rdata));
          check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
          check("rsp_timeout", 32'(rsp_timeout), 32'(sb[0].to));
          check("resp_bus_idle", {30'd0, psel, penable}, 32'd0);
          check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
          if (rsp_ready) begin
            check("access_cycles", 32'(access_cnt), 32'(sb[0].access));
            void'(sb.pop_front());
            access_cnt = 0;
            setup_seen = 0;
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic send(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input int waits, input logic [7:0] data, input bit serr, output int acc);
    exp_t e;
    int   n = 0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      fail("cmd_accept");
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    slv_waits = waits; slv_data = data; slv_err = serr;
    e.wr      = wr;
    e.addr    = addr;
    e.wdata   = wdata;
    e.to      = (waits >= TO);
    e.err     = e.to || serr;
    e.rdata   = (e.to || wr) ? 8'h00 : data;
    e.access  = e.to ? TO : waits + 1;
    e.exp_cyc = cyc + e.access + 2;
    sb.push_back(e);
    acc = cyc;
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom); cmd_write = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !cmd_ready) && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (sb.size() != 0 || !cmd_ready) fail("wait_idle");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bus"}, {29'd0, psel, penable, pwrite}, 32'd0);
    check({tag, "_paddr_pwdata"}, {16'd0, paddr, pwdata}, 32'd0);
    check({tag, "_rsp"}, {21'd0, rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 32'd0);
    check({tag, "_busy_ready"}, {30'd0, busy, cmd_ready}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_prev, bad, n;
    logic [7:0] d;
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #2;
    check_reset_vals("reset");
    preset = 1'b0;

    send(1'b1, 8'h01, 8'h5A, 0, 8'h00, 1'b0, acc_prev);
    send(1'b0, 8'h04, 8'h00, 3, 8'hC3, 1'b0, acc);
    check("back_to_back_accept", 32'(acc - acc_prev), 32'd4);
    send(1'b0, 8'h00, 8'h00, 0, 8'h77, 1'b1, acc);
    send(1'b0, 8'h02, 8'h00, 255, 8'h11, 1'b0, acc);
    wait_idle();
    hold_left = 5;
    send(1'b0, 8'h08, 8'h00, 1, 8'h3C, 1'b0, acc);
    send(1'b1, 8'h09, 8'hA5, 0, 8'h00, 1'b0, acc);

    // reset during the second low-pready ACCESS cycle drops the transfer
    wait_idle();
    send(1'b0, 8'h06, 8'h00, 255, 8'h00, 1'b0, acc);
    @(posedge pclk);
    @(posedge pclk);
    #2 preset = 1'b1;
    @(posedge pclk);
    #2;
    check_reset_vals("midreset");
    preset = 1'b0;
    send(1'b1, 8'h02, 8'h99, 0, 8'h00, 1'b0, acc);

    wait_idle();
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 4));
      send(1'($urandom), 8'($urandom), 8'($urandom), w, 8'($urandom),
           $urandom_range(0, 3) == 0, acc);
    end
    wait_idle();

    // disabled timeout: 100 low-pready ACCESS cycles must not abort
    @(negedge pclk);
    n_cmd_valid = 1'b1; n_cmd_addr = 8'h0C; n_pready = 1'b0;
    @(negedge pclk);
    n_cmd_valid = 1'b0;
    n = 0;
    while (!n_penable && n < 10) begin
      @(negedge pclk);
      n++;
    end
    if (!n_penable) fail("nt_access_start");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (n_rsp_valid || !n_penable || n_paddr != 8'h0C) bad++;
    end
    check("nt_no_abort", 32'(bad), 32'd0);
    d = 8'($urandom);
    n_prdata = d; n_pready = 1'b1;
    @(negedge pclk);
    n_pready = 1'b0;
    check("nt_rsp_valid", 32'(n_rsp_valid), 32'd1);
    check("nt_rsp_rdata", 32'(n_rsp_rdata), 32'(d));
    check("nt_rsp_err_to", {30'd0, n_rsp_err, n_rsp_timeout}, 32'd0);

    repeat (3) @(negedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_bridge_master.md
# apb_bridge_master

Single-outstanding APB requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers toward the timer's APB register slave (TDR/TCR/TSR). It sits between the host/CPU-side control logic and the timer peripheral bus. It handles slave wait states, captures read data and `pslverr`, and enforces a bounded-wait timeout so a hung slave cannot stall the requester.

## Interface
- `ADDR_W`, 8: APB address width.
- `DATA_W`, 8: APB data width (matches timer register width).
- `TIMEOUT_CYCLES`, 16: max consecutive ACCESS cycles with `pready`=0 before abort; 0 disables the timeout.

- `pclk` in 1: single clock; all logic on rising edge.
- `preset` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command (high only in IDLE).
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data (ignored for reads).
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_rdata` out DATA_W: captured `prdata` (reads); 0 for writes.
- `rsp_err` out 1: `pslverr` seen at completion, or timeout.
- `rsp_timeout` out 1: transfer aborted by timeout.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out ADDR_W; `pwdata` out DATA_W: APB address/write data.
- `prdata` in DATA_W; `pready` in 1; `pslverr` in 1: APB slave response.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs registered.
- IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, latch write/addr/wdata, go SETUP.
- SETUP (exactly 1 cycle): `psel`=1, `penable`=0, `paddr`/`pwrite`/`pwdata` = latched command (`pwdata`=0 for reads). Go ACCESS.
- ACCESS: `psel`=1, `penable`=1, address/control/data unchanged from SETUP. Sample `pready`, `prdata`, `pslverr` only here.
  - `pready`=1: complete; capture `prdata` (reads), `rsp_err`=`pslverr`, `rsp_timeout`=0; go RESP.
  - `pready`=0: increment wait counter; if counter reaches TIMEOUT_CYCLES (nonzero), abort: `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0; go RESP.
- RESP: `psel`=`penable`=0, `rsp_valid`=1, response fields stable. On `rsp_ready`=1, go IDLE, clear `rsp_valid`.
- Wait counter cleared on entry to SETUP; width = clog2(TIMEOUT_CYCLES+1), saturates (no wrap) when timeout disabled.
- `cmd_valid` is ignored outside IDLE; no queuing.
- `paddr`, `pwrite`, `pwdata` hold last values in IDLE/RESP; only `psel`/`penable` are deasserted.

## Timing
- Reset (synchronous, `preset`=1 at an edge): state IDLE; `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout`, `busy` = 0; wait counter = 0; `cmd_ready`=1 from the first cycle after reset release.
- Reset mid-transfer: bus deasserted and FSM in IDLE after that edge; in-flight command and any pending response dropped, no `rsp_valid`.
- Command accepted at edge N: `psel`=1 from N+1, `penable`=1 from N+2.
- Zero-wait slave: `pready`=1 in the first ACCESS cycle -> `rsp_valid`=1 from N+3; earliest next accept at N+4 (with `rsp_ready` held high). Minimum 4 cycles per transfer.
- Each wait cycle adds 1 cycle. Timeout: `rsp_valid` rises the cycle after the TIMEOUT_CYCLES-th consecutive low-`pready` ACCESS cycle.
- `pslverr` and `prdata` are don't-care when `pready`=0.
- `rsp_ready` low holds RESP indefinitely; APB stays idle, `cmd_ready`=0.

## Test plan
- Write 8'h5A to `cmd_addr`=8'h01, slave `pready`=1 immediately -> one SETUP, one ACCESS cycle with `pwrite`=1, `pwdata`=8'h5A; `rsp_valid` at accept+3, `rsp_err`=0, `rsp_rdata`=0.
- Read `cmd_addr`=8'h04, slave inserts 3 wait states then returns 8'hC3 -> ACCESS lasts 4 cycles with `paddr` stable, `rsp_rdata`=8'hC3, `rsp_valid` at accept+6.
- Read `cmd_addr`=8'h00, slave responds `pready`=1, `pslverr`=1 -> `rsp_err`=1, `rsp_timeout`=0.
- TIMEOUT_CYCLES=16, `pready` held 0 -> exactly 16 ACCESS cycles, then `psel`=`penable`=0, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0; with TIMEOUT_CYCLES=0 and 100 wait cycles, no abort.
- Hold `rsp_ready`=0 for 5 cycles after `rsp_valid`, with `cmd_valid`=1 -> response fields stable, `cmd_ready`=0, no new SETUP until after the `rsp_ready` handshake.
- Assert `preset` for one cycle during the 2nd ACCESS wait cycle -> next cycle all outputs at reset values, no `rsp_valid`; a subsequent write completes normally.
